// File: rtl/fpmul_stream_wrapper.sv
// Valid/ready streaming front-end for a fixed-latency pipelined FP multiplier.
// Operands are registered toward the core. A valid shift register tracks
// in-flight ops. Results land in a first-word-fall-through FIFO. Credits
// (FIFO entries plus in-flight ops) gate in_ready, so the FIFO cannot overflow.
module fpmul_stream_wrapper #(
  parameter int N       = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic [N-1:0]  core_a,
  output logic [N-1:0]  core_b,
  input  logic [N-1:0]  core_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_z,
  output logic [CW-1:0] level,
  output logic          err_ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic [LATENCY:1] vld_pipe_q, vld_pipe_d;
  logic [LATENCY:0] vld_shift;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  level_q, level_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   mem_q [DEPTH];

  logic accept, capture, pop, full, wr_en;

  // level_q always equals count_q + inflight_q, so in_ready is a pure
  // function of registers and never combinationally follows in_valid/out_ready.
  assign in_ready  = (level_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_z     = mem_q[rd_ptr_q];
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign level     = level_q;
  assign err_ovf   = ovf_q;

  // Next-state: accept/capture/pop handshakes, counters, pointers.
  always_comb begin
    accept     = in_valid & in_ready;
    capture    = vld_pipe_q[LATENCY];
    pop        = out_valid & out_ready;
    full       = (count_q == CW'(DEPTH));
    // A pop at full frees the slot being written this edge.
    wr_en      = capture & (~full | pop);
    core_a_d   = accept ? in_a : core_a_q;
    core_b_d   = accept ? in_b : core_b_q;
    vld_shift  = {vld_pipe_q, accept};
    vld_pipe_d = vld_shift[LATENCY-1:0];
    inflight_d = inflight_q + CW'(accept) - CW'(capture);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    level_d    = count_d + inflight_d;
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    ovf_d      = ovf_q | (capture & full & ~pop);
  end

  // Control and operand state; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a_q   <= '0;
      core_b_q   <= '0;
      vld_pipe_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      vld_pipe_q <= vld_pipe_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Result storage; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= core_z;
  end
endmodule

// File: tb/tb_fpmul_stream_wrapper.sv
// Scoreboard bench for fpmul_stream_wrapper with a 3-cycle delay-line core model.
module tb_fpmul_stream_wrapper;
  localparam int N = 32, LATENCY = 3, DEPTH = 8, CW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err_ovf;
  logic [N-1:0] in_a = '0, in_b = '0, core_a, core_b, core_z, out_z;
  logic [CW-1:0] level;

  fpmul_stream_wrapper #(.N(N), .LATENCY(LATENCY), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_a(core_a), .core_b(core_b), .core_z(core_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .level(level), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  // Normal-range FP32 multiply, truncating; exact for the directed vectors.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  // Core model: result for operands loaded at edge E is sampled at E+3.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1 <= fmul(core_a, core_b);
    p2 <= p1;
  end
  assign core_z = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and monitor
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp = '0;
  int acc_seen = 0, acc_first = 0, rx_cnt = 0, rx_first = 0, rx_last = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        if (acc_seen == 0) begin acc_seen = 1; acc_first = cyc; end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %h expected none (cycle %0d)", out_z, cyc);
        end else begin
          chk("result", out_z, exp_q.pop_front());
        end
        rx_cnt++;
        if (rx_cnt == 1) rx_first = cyc;
        rx_last = cyc;
      end
    end
  end

  task automatic clear_stats();
    acc_seen = 0; rx_cnt = 0;
  endtask

  // Operand source: fixed directed pair or random normal operands.
  logic        use_fix = 1'b1;
  logic [31:0] fix_a, fix_b, fix_z;
  task automatic next_op();
    logic [31:0] a, b;
    if (use_fix) begin
      in_a = fix_a; in_b = fix_b; cur_exp = fix_z;
    end else begin
      a = {1'($urandom), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
      b = {1'($urandom), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
      in_a = a; in_b = b; cur_exp = fmul(a, b);
    end
  endtask

  // mode 0: in_valid=1, toggle out_ready; 1: random both; 2: in_valid=1,
  // out_ready=0; 3: both held high.
  task automatic drive(input int ncyc, input int mode, input int max_acc, output int n_acc);
    logic need_new;
    need_new = 1'b1;
    n_acc = 0;
    for (int c = 0; c < ncyc && n_acc < max_acc; c++) begin
      @(posedge clk); #1;
      if (need_new) next_op();
      case (mode)
        0: begin in_valid = 1'b1; out_ready = ~out_ready; end
        1: begin in_valid = 1'($urandom); out_ready = 1'($urandom); end
        2: begin in_valid = 1'b1; out_ready = 1'b0; end
        default: begin in_valid = 1'b1; out_ready = 1'b1; end
      endcase
      @(negedge clk);
      if (mode == 0) chk("level_bound", 32'(level <= CW'(DEPTH)), 32'd1);
      if (mode == 3) chk("stream_in_ready", 32'(in_ready), 32'd1);
      need_new = in_valid && in_ready;
      if (need_new) n_acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk); t++;
    end
    chk({name, "_drain_done"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk({name, "_level_zero"}, 32'(level), 32'd0);
  endtask

  int n;
  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf), 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. single op 1.0 * 2.0
    fix_a = 32'h3F800000; fix_b = 32'h40000000; fix_z = 32'h40000000;
    clear_stats();
    drive(5, 3, 1, n);
    drain("single");
    chk("single_rx_cnt", 32'(rx_cnt), 32'd1);
    chk("single_latency", 32'(rx_first - acc_first), 32'(LATENCY + 1));

    // 2. streaming 20 ops of 3.0 * 3.0
    fix_a = 32'h40400000; fix_b = 32'h40400000; fix_z = 32'h41100000;
    clear_stats();
    drive(40, 3, 20, n);
    drain("stream");
    chk("stream_accepts", 32'(n), 32'd20);
    chk("stream_rx_cnt", 32'(rx_cnt), 32'd20);
    chk("stream_latency", 32'(rx_first - acc_first), 32'(LATENCY + 1));
    chk("stream_back_to_back", 32'(rx_last - rx_first), 32'd19);

    // 3. backpressure: credits stop accepts at DEPTH
    use_fix = 1'b0;
    clear_stats();
    out_ready = 1'b0;
    drive(12, 2, 100, n);
    repeat (3) @(negedge clk);
    chk("bp_accepts", 32'(n), 32'(DEPTH));
    chk("bp_level", 32'(level), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    drain("bp");
    chk("bp_rx_cnt", 32'(rx_cnt), 32'(DEPTH));
    chk("bp_err_ovf", 32'(err_ovf), 32'd0);

    // 4. full FIFO with simultaneous capture and pop, pointer wrap
    clear_stats();
    out_ready = 1'b0;
    drive(12, 2, DEPTH, n);
    drive(200, 0, 4 * DEPTH, n);
    chk("full_toggle_accepts", 32'(n), 32'(4 * DEPTH));
    drain("full_toggle");
    chk("full_toggle_err_ovf", 32'(err_ovf), 32'd0);

    // 5. reset with 3 in flight and 5 buffered
    out_ready = 1'b0;
    drive(20, 2, DEPTH, n);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_core_b", core_b, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    clear_stats();
    repeat (8) @(negedge clk);
    chk("postrst_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);

    // 6. random in_valid/out_ready over 1000 ops
    clear_stats();
    drive(20000, 1, 1000, n);
    chk("rand_accepts", 32'(n), 32'd1000);
    drain("rand");
    chk("rand_rx_cnt", 32'(rx_cnt), 32'd1000);
    chk("rand_err_ovf", 32'(err_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpmul_stream_wrapper.md
Name: fpmul_stream_wrapper

Overview:
Parametrised valid/ready streaming front-end for a fixed-latency pipelined FP multiplier core such as FPmul. It drives the core's operand inputs and tracks in-flight operations with a valid shift register. It captures each core result into an output FIFO. A credit scheme guarantees the FIFO never overflows, so the datapath supports backpressure, which the bare core lacks. The block sits between the stimulus source (dataGen successor) and the result sink (dataSink successor).

Parameters:
N, 32, operand/result width in bits.
LATENCY, 3, core latency: the result for operands loaded at clock edge E is sampled at edge E+LATENCY (LATENCY >= 1).
DEPTH, 8, output FIFO depth in entries (power of two, >= 2).
CW, $clog2(DEPTH+1), width of the occupancy/credit counters.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept an operand pair.
in_a  in  N  operand A.
in_b  in  N  operand B.
core_a  out  N  registered operand A to the multiplier core.
core_b  out  N  registered operand B to the multiplier core.
core_z  in  N  multiplier core result.
out_valid  out  1  result available at out_z.
out_ready  in  1  sink accepts result.
out_z  out  N  result at FIFO head (first-word fall-through).
level  out  CW  FIFO entries plus in-flight operations (credits used).
err_ovf  out  1  sticky flag: a write occurred while the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - core_a = core_b = 0; valid shift register cleared; inflight = 0.
  - FIFO pointers and count = 0; level = 0; err_ovf = 0.
  - out_valid = 0; in_ready = 1.
  - Reset mid-operation discards all in-flight and buffered results; no partial output follows.
- Credit rule: in_ready = (fifo_count + inflight) < DEPTH.
  - Depends on registers only; no combinational path from in_valid or out_ready.
- Accept: when in_valid & in_ready at edge E:
  - core_a <= in_a, core_b <= in_b, sr[1] <= 1.
  - With no accept, core_a/core_b hold their values and sr[1] <= 0.
- Valid pipeline: sr[k] <= sr[k-1] for k = 2..LATENCY.
  - When sr[LATENCY] = 1 at an edge, core_z is written to mem[wr_ptr] and wr_ptr increments mod DEPTH.
- inflight counter:
  - +1 on accept, -1 on capture.
  - Unchanged on a simultaneous accept and capture.
- FIFO:
  - out_valid = (fifo_count != 0); out_z = mem[rd_ptr].
  - Pop on out_valid & out_ready: rd_ptr increments mod DEPTH.
  - Simultaneous capture and pop: count unchanged, both pointers advance. This also applies at count = DEPTH, where the pop frees the slot being written.
  - Pointers wrap mod DEPTH.
- Overflow: a capture with fifo_count = DEPTH and no pop sets err_ovf (sticky until reset) and the write is dropped. This cannot occur under the credit rule; it exists for verification only.
- out_z while out_valid = 0: value is don't-care; the bench must not check it.
- level = fifo_count + inflight, registered, updated every edge.
- Latency:
  - Accept at edge E; out_valid rises after edge E+LATENCY, i.e. LATENCY+1 cycles from in_valid to out_valid with an empty FIFO.
  - Throughput is one result per cycle with out_ready held high.
- Ordering: results leave strictly in acceptance order; no reordering, drops or duplication.

Test Plan:
1. Single op: in_a=0x3F800000 (1.0), in_b=0x40000000 (2.0), out_ready=1 -> out_valid rises after edge E+3, out_z=0x40000000, one beat, level returns to 0.
2. Streaming: 20 back-to-back ops (3.0*3.0, i.e. 0x40400000*0x40400000), out_ready=1 -> in_ready stays 1, 20 results of 0x41100000 on consecutive cycles starting LATENCY+1 cycles after the first accept.
3. Backpressure: out_ready=0, in_valid=1 -> exactly 8 accepts, then in_ready=0 with level=8. After the 3-cycle drain, out_valid=1 and the FIFO holds 8 entries. Raise out_ready -> 8 results in order, err_ovf stays 0.
4. Full FIFO with simultaneous capture and pop: hold level at DEPTH, toggle out_ready every cycle with in_valid=1 -> count never exceeds 8, no lost or duplicated results, pointer wrap-around exercised over more than 3*DEPTH ops.
5. Reset mid-operation: assert rst_n=0 with 3 ops in flight and 5 buffered -> all outputs at reset values immediately (async). After release: out_valid=0, in_ready=1, none of the old results appear.
6. Random in_valid/out_ready (about 50% each) over 1000 ops against a delay-line core model -> scoreboard matches every result in order, err_ovf=0.
